pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/pipelined_barrel_shifter_if.sv | 26 ++
 rtl/pipelined_barrel_shifter.sv | 99 +++++++++
 tb/tb_pipelined_barrel_shifter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for the pipelined barrel shifter: operand/command on the
// input side, result on the output side, each with its own valid/ready pair.
interface pipelined_barrel_shifter_if #(
  parameter int N = 3
);
  localparam int W = 2 ** N;

  logic [W-1:0] a;
  logic [N-1:0] amt;
  logic [2:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output a, amt, mode, in_valid, out_ready,
    input  in_ready, y, out_valid
  );

  modport slave (
    input  a, amt, mode, in_valid, out_ready,
    output in_ready, y, out_valid
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// N-stage barrel shifter/rotator. Left operations reverse on entry and exit
// around right-only stages; a single advance signal stalls the whole pipe.
module pipelined_barrel_shifter #(
  parameter int N = 3
) (
  input logic                        clk,
  input logic                        reset_n,
  pipelined_barrel_shifter_if.slave  bus
);
  localparam int W = 2 ** N;

  function automatic logic [W-1:0] bit_rev(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i] = d[W-1-i];
    end
    return r;
  endfunction

  logic [W-1:0] data_q  [N];
  logic [2:0]   mode_q  [N];
  logic [N-1:0] amt_q   [N];
  logic         valid_q [N];
  logic [W-1:0] stg_d   [N];
  logic         advance_s;
  logic [W-1:0] entry_s;

  assign advance_s     = !(valid_q[N-1] && !bus.out_ready);
  assign bus.in_ready  = advance_s;
  assign bus.y         = data_q[N-1];
  assign bus.out_valid = valid_q[N-1];
  assign entry_s       = (bus.mode == 3'b001 || bus.mode == 3'b011) ? bit_rev(bus.a) : bus.a;

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int S = 2 ** k;
    logic [W-1:0] d_s;
    logic [2:0]   m_s;
    logic         sh_s;
    logic [W-1:0] r_s;

    if (k == 0) begin : g_first
      assign d_s  = entry_s;
      assign m_s  = bus.mode;
      assign sh_s = bus.amt[0];
    end else begin : g_next
      assign d_s  = data_q[k-1];
      assign m_s  = mode_q[k-1];
      assign sh_s = amt_q[k-1][k];
    end

    // Right shift/rotate by 2**k when this stage's amount bit is set.
    always_comb begin
      r_s = d_s;
      if (sh_s) begin
        case (m_s)
          3'b000, 3'b001: r_s = {d_s[S-1:0], d_s[W-1:S]};
          3'b010, 3'b011: r_s = {{S{1'b0}}, d_s[W-1:S]};
          3'b100:         r_s = {{S{d_s[W-1]}}, d_s[W-1:S]};
          default:        r_s = d_s;
        endcase
      end else begin
        r_s = d_s;
      end
    end

    if (k == N - 1) begin : g_exit
      assign stg_d[k] = (m_s == 3'b001 || m_s == 3'b011 || m_s == 3'b101) ? bit_rev(r_s) : r_s;
    end else begin : g_mid
      assign stg_d[k] = r_s;
    end
  end

  // Stage registers: data only loads with a valid token so y holds across bubbles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= {W{1'b0}};
        mode_q[k]  <= 3'b000;
        amt_q[k]   <= {N{1'b0}};
      end
    end else if (advance_s) begin
      valid_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        data_q[0] <= stg_d[0];
        mode_q[0] <= bus.mode;
        amt_q[0]  <= bus.amt;
      end
      for (int k = 1; k < N; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          data_q[k] <= stg_d[k];
          mode_q[k] <= mode_q[k-1];
          amt_q[k]  <= amt_q[k-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at N=3 (W=8).
module tb_pipelined_barrel_shifter;
  localparam int N = 3;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n;
  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_barrel_shifter_if #(.N(N)) bus ();

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  function automatic logic [7:0] model(input logic [7:0] a, input logic [2:0] amt, input logic [2:0] mode);
    logic [15:0] dbl;
    logic [7:0] r;
    dbl = {a, a};
    r = a;
    case (mode)
      3'd0: begin dbl = dbl >> amt; r = dbl[7:0]; end
      3'd1: begin dbl = dbl << amt; r = dbl[15:8]; end
      3'd2: r = a >> amt;
      3'd3: r = a << amt;
      3'd4: r = $signed(a) >>> amt;
      3'd5: for (int i = 0; i < 8; i++) r[i] = a[7-i];
      default: r = a;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.a = 8'h00; bus.amt = 3'd0; bus.mode = 3'd0; bus.out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests_run++;
    if (bus.y !== 8'h00) begin tests_failed++; $display("FAIL reset_y: got %h want 00", bus.y); end
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_valid: got %b want 0", bus.out_valid); end
    @(negedge clk);
  endtask

  task automatic test_modes();
    logic [7:0] tbl [6];
    logic [7:0] exp;
    int n_in = 0, n_out = 0, first_in = -1, first_out = -1, last_out = -1;
    tbl = '{8'hD2, 8'hB4, 8'h12, 8'hB0, 8'hF2, 8'h69};
    for (int c = 0; c < 16; c++) begin
      bus.in_valid = (n_in < 6); bus.a = 8'h96; bus.amt = 3'd3; bus.mode = 3'(n_in); bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL modes_spurious: y=%h with nothing expected", bus.y);
        end else begin
          exp = exp_q.pop_front();
          if (bus.y !== exp) begin tests_failed++; $display("FAIL modes_y: got %h want %h", bus.y, exp); end
        end
        if (first_out < 0) first_out = c;
        last_out = c; n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(tbl[n_in]);
        if (first_in < 0) first_in = c;
        n_in++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (first_out - first_in !== 3) begin tests_failed++; $display("FAIL modes_latency: got %0d want 3", first_out - first_in); end
    tests_run++;
    if (n_out !== 6 || last_out - first_out !== 5) begin
      tests_failed++; $display("FAIL modes_throughput: got %0d results over %0d cycles want 6 over 5", n_out, last_out - first_out);
    end
  endtask

  task automatic test_amt_zero();
    logic [7:0] exp;
    logic [2:0] modes [6];
    int n_in = 0, n_out = 0;
    modes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    for (int c = 0; c < 14; c++) begin
      bus.in_valid = (n_in < 6); bus.a = 8'h96; bus.out_ready = 1'b1;
      bus.mode = (n_in < 6) ? modes[n_in] : 3'd0;
      bus.amt = (n_in == 5) ? 3'd5 : 3'd0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL amt0_spurious: y=%h with nothing expected", bus.y);
        end else begin
          exp = exp_q.pop_front();
          if (bus.y !== exp) begin tests_failed++; $display("FAIL amt0_y: got %h want %h", bus.y, exp); end
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin exp_q.push_back(8'h96); n_in++; end
      @(negedge clk);
    end
    tests_run++;
    if (n_out !== 6) begin tests_failed++; $display("FAIL amt0_count: got %0d want 6", n_out); end
  endtask

  task automatic test_stall();
    logic [7:0] va [8];
    logic [2:0] vamt [8];
    logic [2:0] vmode [8];
    logic [7:0] exp, hold_y;
    logic hold_v;
    int idx = 0, delivered = 0;
    for (int i = 0; i < 8; i++) begin
      va[i] = 8'($urandom); vamt[i] = 3'($urandom_range(0, 7)); vmode[i] = 3'($urandom_range(0, 7));
    end
    for (int c = 0; c < 40 && (idx < 8 || exp_q.size() > 0); c++) begin
      if (idx < 8) begin
        bus.in_valid = 1'b1; bus.a = va[idx]; bus.amt = vamt[idx]; bus.mode = vmode[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = !(c >= 5 && c <= 8);
      #1;
      if (c == 5) begin
        hold_y = bus.y; hold_v = bus.out_valid;
        tests_run++;
        if (hold_v !== 1'b1) begin tests_failed++; $display("FAIL stall_full: out_valid got %b want 1", hold_v); end
      end
      if (c >= 5 && c <= 8) begin
        tests_run++;
        if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_in_ready: cycle %0d got %b want 0", c, bus.in_ready); end
        if (c > 5) begin
          tests_run++;
          if (bus.y !== hold_y || bus.out_valid !== hold_v) begin
            tests_failed++; $display("FAIL stall_hold: cycle %0d got y=%h v=%b want y=%h v=%b", c, bus.y, bus.out_valid, hold_y, hold_v);
          end
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL stall_spurious: y=%h with nothing expected", bus.y);
        end else begin
          exp = exp_q.pop_front();
          if (bus.y !== exp) begin tests_failed++; $display("FAIL stall_y: got %h want %h", bus.y, exp); end
        end
        delivered++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(va[idx], vamt[idx], vmode[idx]));
        idx++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (delivered !== 8 || exp_q.size() !== 0) begin
      tests_failed++; $display("FAIL stall_delivered: got %0d left %0d want 8 left 0", delivered, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bubbles();
    logic vin [24];
    logic [7:0] exp;
    logic [7:0] ra;
    logic [2:0] ramt, rmode;
    logic want_v;
    for (int c = 0; c < 20; c++) begin
      ra = 8'($urandom); ramt = 3'($urandom_range(0, 7)); rmode = 3'($urandom_range(0, 7));
      bus.in_valid = (c < 12) && (c % 2 == 0); bus.a = ra; bus.amt = ramt; bus.mode = rmode; bus.out_ready = 1'b1;
      #1;
      want_v = (c >= 3) ? vin[c-3] : 1'b0;
      tests_run++;
      if (bus.out_valid !== want_v) begin tests_failed++; $display("FAIL bubble_valid: cycle %0d got %b want %b", c, bus.out_valid, want_v); end
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL bubble_spurious: y=%h with nothing expected", bus.y);
        end else begin
          exp = exp_q.pop_front();
          if (bus.y !== exp) begin tests_failed++; $display("FAIL bubble_y: got %h want %h", bus.y, exp); end
        end
      end
      vin[c] = bus.in_valid && bus.in_ready;
      if (vin[c]) exp_q.push_back(model(ra, ramt, rmode));
      @(negedge clk);
    end
    tests_run++;
    if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL bubble_drain: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 14; c++) begin
      bus.in_valid = (c < 2); bus.a = 8'h96; bus.amt = 3'd3; bus.mode = 3'(c); bus.out_ready = 1'b1;
      reset_n = (c == 2) ? 1'b0 : 1'b1;
      #1;
      if (c == 3) begin
        tests_run++;
        if (bus.y !== 8'h00) begin tests_failed++; $display("FAIL midreset_y: got %h want 00", bus.y); end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready); end
      end
      if (c >= 3) begin
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_ghost: cycle %0d got out_valid=%b want 0", c, bus.out_valid); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_amt_zero();
    test_stall();
    test_bubbles();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
